// File: rtl/dense_layer_engine_if.sv
// Handshake and memory-port bundle for the dense layer engine.
// master: the engine side; slave: the environment (stream source/sink, ROMs, control).
// Address widths are derived from the layer geometry so both ends agree.
interface dense_layer_engine_if #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 784,
  parameter int N_OUT  = 64
) ();
  localparam int A_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
  localparam int K_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic              start;
  logic [1:0]        act_mode;
  logic              s_tvalid;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tready;
  logic              w_en;
  logic [A_W-1:0]    w_addr;
  logic [DATA_W-1:0] w_data;
  logic              b_en;
  logic [K_W-1:0]    b_addr;
  logic [DATA_W-1:0] b_data;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tready;
  logic              m_tlast;
  logic              busy;
  logic              done;

  modport master (
    input  start, act_mode, s_tvalid, s_tdata, w_data, b_data, m_tready,
    output s_tready, w_en, w_addr, b_en, b_addr, m_tvalid, m_tdata, m_tlast, busy, done
  );

  modport slave (
    output start, act_mode, s_tvalid, s_tdata, w_data, b_data, m_tready,
    input  s_tready, w_en, w_addr, b_en, b_addr, m_tvalid, m_tdata, m_tlast, busy, done
  );
endinterface

// File: rtl/dense_layer_engine.sv
// Fixed-point dense layer: buffers one input vector, then one MAC pass per neuron with bias, saturation, optional ReLU.
// Latency: first result valid N_IN+3 cycles after MAC entry of each neuron; one result per neuron.
// Backpressure: m_tready low holds the result and stalls the pass; s_tready is high only while loading.
module dense_layer_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_IN   = 784,
  parameter int N_OUT  = 64,
  parameter int ACC_W  = 48
) (
  input logic clk,
  input logic rst,
  dense_layer_engine_if.master bus
);
  localparam int A_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
  localparam int K_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int I_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int C_W = $clog2(N_IN + 3);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_OUT, S_DONE} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0]   buf_mem [N_IN];
  logic [I_W-1:0]             ld_idx, mac_idx;
  logic [C_W-1:0]             cnt;
  logic [K_W-1:0]             k, nk;
  logic [A_W-1:0]             base, nbase;
  logic [1:0]                 mode_q;
  logic signed [ACC_W-1:0]    acc;
  logic signed [DATA_W-1:0]   bias_q;
  logic                       rd_vld;
  logic                       w_en_q, b_en_q, m_tvalid_q, m_tlast_q;
  logic [A_W-1:0]             w_addr_q;
  logic [K_W-1:0]             b_addr_q;
  logic [DATA_W-1:0]          m_tdata_q;

  logic                       ld_beat, ld_last, out_hs, last_k, mac_last, enter_mac;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sh;
  logic [DATA_W-1:0]          res;

  assign bus.s_tready = (state == S_LOAD);
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.w_en     = w_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.b_en     = b_en_q;
  assign bus.b_addr   = b_addr_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tlast  = m_tlast_q;

  // Handshake decode, next-neuron addressing and the result arithmetic.
  always_comb begin
    ld_beat   = (state == S_LOAD) && bus.s_tvalid;
    ld_last   = ld_beat && (ld_idx == I_W'(N_IN - 1));
    out_hs    = (state == S_OUT) && m_tvalid_q && bus.m_tready;
    last_k    = (k == K_W'(N_OUT - 1));
    mac_last  = (state == S_MAC) && (cnt == C_W'(N_IN + 2));
    enter_mac = ld_last || (out_hs && !last_k);
    nk        = (state == S_OUT) ? k + 1'b1 : k;
    nbase     = (state == S_OUT) ? base + A_W'(N_IN) : base;
    prod      = buf_mem[mac_idx] * $signed(bus.w_data);
    acc_sh    = acc >>> FRAC_W;
    if (acc_sh > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
    else if (acc_sh < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
    else                       res = acc_sh[DATA_W-1:0];
    if (mode_q == 2'd1 && res[DATA_W-1]) res = '0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_LOAD;
      S_LOAD:  if (ld_last) state_nxt = S_MAC;
      S_MAC:   if (mac_last) state_nxt = S_OUT;
      S_OUT:   if (out_hs) state_nxt = last_k ? S_DONE : S_MAC;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Input vector buffer; contents are don't-care until loaded, so no reset.
  always_ff @(posedge clk) begin
    if (ld_beat) buf_mem[ld_idx] <= $signed(bus.s_tdata);
  end

  // Datapath: ROM addressing, accumulation, bias, result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_idx <= '0; mac_idx <= '0; cnt <= '0; k <= '0; base <= '0; mode_q <= '0;
      acc <= '0; bias_q <= '0; rd_vld <= 1'b0;
      w_en_q <= 1'b0; w_addr_q <= '0; b_en_q <= 1'b0; b_addr_q <= '0;
      m_tvalid_q <= 1'b0; m_tlast_q <= 1'b0; m_tdata_q <= '0;
    end else begin
      rd_vld <= w_en_q;
      if (state == S_IDLE && bus.start) mode_q <= bus.act_mode;
      if (ld_beat) ld_idx <= ld_last ? '0 : ld_idx + 1'b1;
      if (enter_mac) begin
        k        <= nk;
        base     <= nbase;
        w_en_q   <= 1'b1;
        w_addr_q <= nbase;
        b_en_q   <= 1'b1;
        b_addr_q <= nk;
        cnt      <= '0;
        mac_idx  <= '0;
        acc      <= '0;
      end else begin
        b_en_q <= 1'b0;
        if (w_en_q) begin
          if (cnt == C_W'(N_IN - 1)) w_en_q <= 1'b0;
          else                       w_addr_q <= w_addr_q + 1'b1;
        end
        if (state == S_MAC) cnt <= mac_last ? '0 : cnt + 1'b1;
        if (state == S_MAC && cnt == C_W'(1)) bias_q <= $signed(bus.b_data);
        if (rd_vld) begin
          acc     <= acc + ACC_W'(prod);
          mac_idx <= (mac_idx == I_W'(N_IN - 1)) ? '0 : mac_idx + 1'b1;
        end else if (state == S_MAC && cnt == C_W'(N_IN + 1)) begin
          acc <= acc + (ACC_W'(bias_q) <<< FRAC_W);
        end
        if (mac_last) begin
          m_tdata_q  <= res;
          m_tvalid_q <= 1'b1;
          m_tlast_q  <= last_k;
        end
        if (out_hs && last_k) begin
          k    <= '0;
          base <= '0;
        end
      end
      if (out_hs) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dense_layer_engine.sv
// Scoreboard bench for dense_layer_engine with N_IN=4, N_OUT=3, Q8.8 operands.
// Expected results are queued when a pass is launched and popped on each output handshake.
// ROMs are modelled with one-cycle read latency; m_tready stalls are configurable per pass.
module tb_dense_layer_engine;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int NI = 4;
  localparam int NO = 3;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dense_layer_engine_if #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO)) bus ();

  dense_layer_engine #(.DATA_W(DW), .FRAC_W(FW), .N_IN(NI), .N_OUT(NO), .ACC_W(48)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  exp_t sbq[$];
  logic [DW-1:0] inp[NI];
  logic [DW-1:0] wmem[NI*NO];
  logic [DW-1:0] bmem[NO];
  bit addr_err = 0;
  int stall_cfg = 0;
  int done_cnt = 0;
  int cyc = 0;
  int entry_cyc = 0;
  bit prev_wen = 0, prev_vld = 0, holding = 0;
  logic [DW-1:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ROM models with one-cycle read latency and range checking.
  always @(posedge clk) begin
    if (bus.w_en) begin
      if (int'(bus.w_addr) >= NI*NO) addr_err <= 1'b1;
      else bus.w_data <= wmem[bus.w_addr];
    end
    if (bus.b_en) begin
      if (int'(bus.b_addr) >= NO) addr_err <= 1'b1;
      else bus.b_data <= bmem[bus.b_addr];
    end
  end

  // Result sink: holds m_tready low for stall_cfg cycles after each m_tvalid rise.
  initial begin
    int wc;
    wc = 0;
    bus.m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_tvalid && !bus.m_tready) begin
        if (wc >= stall_cfg) bus.m_tready = 1'b1;
        else wc++;
      end else begin
        bus.m_tready = 1'b0;
        wc = 0;
      end
    end
  end

  // Monitor: latency, hold-while-stalled, scoreboard compare, done counting.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) done_cnt++;
    if (bus.w_en && !prev_wen) entry_cyc = cyc;
    if (bus.m_tvalid && !prev_vld) check("latency", cyc - entry_cyc, NI + 3);
    if (bus.m_tvalid && holding) check("stable", bus.m_tdata, held);
    if (bus.m_tvalid && bus.m_tready) begin
      if (sbq.size() == 0) check("extra_out", 1, 0);
      else begin
        e = sbq.pop_front();
        check("result", bus.m_tdata, e.d);
        check("tlast", bus.m_tlast, e.last);
      end
    end
    holding  = bus.m_tvalid && !bus.m_tready;
    held     = bus.m_tdata;
    prev_wen = bus.w_en;
    prev_vld = bus.m_tvalid;
  end

  function automatic logic [DW-1:0] model(input int k, input bit relu);
    longint acc;
    acc = 0;
    for (int i = 0; i < NI; i++)
      acc += longint'($signed(inp[i])) * longint'($signed(wmem[k*NI+i]));
    acc += longint'($signed(bmem[k])) * 256;
    acc = acc >>> FW;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return 16'(acc);
  endfunction

  task automatic fill(input logic [DW-1:0] x, input logic [DW-1:0] w, input logic [DW-1:0] b);
    for (int i = 0; i < NI; i++) inp[i] = x;
    for (int i = 0; i < NI*NO; i++) wmem[i] = w;
    for (int i = 0; i < NO; i++) bmem[i] = b;
  endtask

  task automatic fill_rand();
    logic [DW-1:0] t;
    for (int i = 0; i < NI; i++) begin t = 16'($urandom_range(0, 1023)); inp[i] = t - 16'd512; end
    for (int i = 0; i < NI*NO; i++) begin t = 16'($urandom_range(0, 1023)); wmem[i] = t - 16'd512; end
    for (int i = 0; i < NO; i++) begin t = 16'($urandom_range(0, 1023)); bmem[i] = t - 16'd512; end
  endtask

  task automatic push_const(input logic [DW-1:0] v);
    exp_t e;
    for (int k = 0; k < NO; k++) begin e.d = v; e.last = (k == NO-1); sbq.push_back(e); end
  endtask

  task automatic push_model(input bit relu);
    exp_t e;
    for (int k = 0; k < NO; k++) begin e.d = model(k, relu); e.last = (k == NO-1); sbq.push_back(e); end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {bus.s_tready, bus.w_en, bus.b_en, bus.m_tvalid, bus.m_tlast, bus.busy, bus.done}, 0);
    check({tag, "_dat"}, {bus.m_tdata, bus.w_addr, bus.b_addr}, 0);
  endtask

  task automatic run_pass(input logic [1:0] mode, input int gap, input int stall, input bit poke, input bit abort);
    bit ok;
    stall_cfg = stall;
    done_cnt = 0;
    bus.act_mode = mode;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.act_mode = ~mode;
    check("busy_run", bus.busy, 1);
    for (int i = 0; i < NI; i++) begin
      repeat (gap) tick();
      bus.s_tvalid = 1'b1;
      bus.s_tdata = inp[i];
      ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        ok = bus.s_tready;
        @(posedge clk);
        #1;
      end
      if (!ok) check("load_timeout", 0, 1);
      bus.s_tvalid = 1'b0;
    end
    if (abort) begin
      ok = 0;
      for (int t = 0; t < 500 && !ok; t++) begin
        @(negedge clk);
        ok = bus.b_en && (bus.b_addr == 2'd1);
      end
      check("n1_reached", ok, 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      check("n0_consumed", sbq.size(), 0);
      sbq.delete();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      return;
    end
    if (poke) begin
      repeat (2) tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = bus.done;
    end
    check("done_seen", ok, 1);
    repeat (3) tick();
    check("done_pulses", done_cnt, 1);
    check("busy_idle", bus.busy, 0);
    check("sb_empty", sbq.size(), 0);
  endtask

  initial begin
    exp_t e;
    bus.start = 1'b0;
    bus.act_mode = 2'd0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    fill(16'h0100, 16'h0080, 16'h0000); push_const(16'h0200); run_pass(2'd0, 0, 0, 0, 0);
    fill(16'h0100, 16'hFF00, 16'h0080); push_const(16'hFC80); run_pass(2'd0, 0, 0, 0, 0);
    push_const(16'h0000); run_pass(2'd1, 0, 0, 0, 0);
    fill(16'h7FFF, 16'h7FFF, 16'h0000); push_const(16'h7FFF); run_pass(2'd0, 0, 0, 0, 0);
    fill(16'h7FFF, 16'h8000, 16'h0000); push_const(16'h8000); run_pass(2'd0, 0, 0, 0, 0);

    fill_rand(); push_model(0); run_pass(2'd0, 3, 10, 0, 0);
    fill_rand(); push_model(1); run_pass(2'd1, 0, 2, 1, 0);

    fill_rand();
    e.d = model(0, 0); e.last = 1'b0; sbq.push_back(e);
    run_pass(2'd0, 0, 0, 0, 1);
    push_model(0); run_pass(2'd0, 1, 0, 0, 0);

    check("addr_range", addr_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dense_layer_engine.md
DENSE_LAYER_ENGINE -- requirements
Module: dense_layer_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed fixed-point sample/weight/bias/result width.
REQ-002 SHALL have parameter FRAC_W, default 8, fractional bits of all fixed-point operands.
REQ-003 SHALL have parameter N_IN, default 784, inputs per vector.
REQ-004 SHALL have parameter N_OUT, default 64, neurons per layer.
REQ-005 SHALL have parameter ACC_W, default 48, accumulator width.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a layer pass.
REQ-009 SHALL have port act_mode  input  2  activation: 0 identity, 1 ReLU, 2/3 identity.
REQ-010 SHALL have port s_tvalid / s_tdata / s_tready  input / input / output  1 / DATA_W / 1  input-vector stream.
REQ-011 SHALL have port w_en / w_addr / w_data  output / output / input  1 / clog2(N_IN*N_OUT) / DATA_W  weight ROM read, 1-cycle latency.
REQ-012 SHALL have port b_en / b_addr / b_data  output / output / input  1 / clog2(N_OUT) / DATA_W  bias ROM read, 1-cycle latency.
REQ-013 SHALL have port m_tvalid / m_tdata / m_tready / m_tlast  output / output / input / output  1 / DATA_W / 1 / 1  result stream.
REQ-014 SHALL have port busy / done  output / output  1 / 1  pass in progress / one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> MAC -> OUT -> (MAC for next neuron | DONE) -> IDLE.
REQ-016 IDLE: start=1 SHALL move to LOAD and latch act_mode for the whole pass; start outside IDLE SHALL be ignored.
REQ-017 LOAD: s_tready SHALL be 1; each beat with s_tvalid&s_tready SHALL store s_tdata in internal buffer index 0..N_IN-1 in arrival order; after beat N_IN-1, SHALL enter MAC; s_tready SHALL be 0 in all other states.
REQ-018 MAC for neuron k: w_addr SHALL be k*N_IN+i for i=0..N_IN-1 on consecutive cycles with w_en=1; b_addr=k with b_en=1 on entry.
REQ-019 Each product buffer[i]*w_data SHALL be full 2*DATA_W signed, sign-extended into ACC_W accumulator cleared at MAC entry.
REQ-020 After last product, bias SHALL be added as sign-extend(b_data) << FRAC_W.
REQ-021 Result SHALL be acc >>> FRAC_W (arithmetic, truncate toward minus infinity), then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then activation applied (ReLU: negative -> 0).
REQ-022 m_tvalid SHALL rise exactly N_IN+3 cycles after MAC entry; m_tdata SHALL hold its value while m_tvalid=1 and m_tready=0.
REQ-023 OUT: on m_tvalid&m_tready, SHALL drop m_tvalid and enter MAC for k+1, or DONE if k=N_OUT-1; m_tlast SHALL be 1 only with the neuron N_OUT-1 result.
REQ-024 DONE SHALL assert done for exactly one cycle and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-025 Neuron index and buffer index SHALL wrap to 0 at pass end; no address SHALL exceed N_IN*N_OUT-1.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE and s_tready, w_en, b_en, m_tvalid, m_tlast, busy, done, m_tdata, w_addr, b_addr to 0, counters and accumulator to 0.
REQ-027 Reset mid-pass SHALL discard partial results; first start after rst release SHALL run a complete, correct pass.

Verification (N_IN=4, N_OUT=3, DATA_W=16, FRAC_W=8)
REQ-028 Inputs 0x0100, weights 0x0080, bias 0, mode 0 -> three results 0x0200, m_tlast on third, done pulse once.
REQ-029 Inputs 0x0100, weights 0xFF00, bias 0x0080 -> mode 0 results 0xFC80; mode 1 results 0x0000.
REQ-030 Inputs 0x7FFF, weights 0x7FFF -> 0x7FFF; weights 0x8000 -> 0x8000 (saturation both rails).
REQ-031 s_tvalid gaps of 3 cycles during LOAD, m_tready low 10 cycles per result -> no lost/duplicated data, m_tdata stable while stalled, order neuron 0,1,2.
REQ-032 rst pulse during MAC of neuron 1 -> all outputs 0 within same cycle, busy 0; start pulse while busy -> ignored, pass unaffected.
